hps_bridge_ctrl: RTL and testbench
==================================

// Module: hps_bridge_ctrl
// PURPOSE
//  Sequences the 128-bit HPS<->FPGA PIO bridge of the plate-recognition SoC.
//  Decodes the HPS command word and runs the 4-phase handshakes on the from-HPS and to-HPS PIOs.
//  Forwards HPS words to the recognition datapath (valid/ready) and buffers datapath results in a FIFO.
//  Publishes a 32-bit status word back to the HPS.
// PARAMETERS
//  TX_DEPTH     8    result FIFO depth, power of 2, 2..128
//  WDOG_CYCLES  4096 handshake timeout in clk cycles (WDOG_EN only), >=2
// PORTS
//  clk_clk         in  1   single clock, all logic
//  reset_reset     in  1   asynchronous, active-high reset
//  hps_cmd         in  32  command PIO: [31:24] tag, [7:0] opcode
//  rx_data         in  128 from-HPS word
//  rx_data_ready   in  1   HPS: rx_data valid (level, 4-phase)
//  rx_ack          out 1   to HPS: word captured (block_read)
//  tx_data         out 128 to-HPS word
//  tx_read_request in  1   HPS: requests next result (level, 4-phase)
//  tx_ack          out 1   to HPS: tx_data valid (block_read)
//  s_data          out 128 word to datapath
//  s_valid         out 1   s_data valid
//  s_ready         in  1   datapath accepts
//  r_data          in  128 result from datapath
//  r_valid         in  1   result valid
//  r_ready         out 1   FIFO not full
//  status          out 32  status PIO word
// BEHAVIOUR
//  Reset: all outputs 0. running=0, FIFO empty, last_tag=0, FSMs idle, counters 0.
//  Sync: rx_data_ready and tx_read_request pass through 2-FF synchronisers. Data buses are stable by protocol.
//  Cmd: hps_cmd is registered twice (q1, q2). A command executes once, when q1==q2 and q2[31:24]!=last_tag.
//    - last_tag is then set to q2[31:24]. Latency: 3 clks from hps_cmd change to effect.
//    - Opcodes: 01 START (running=1), 02 STOP (running=0), 03 FLUSH, 04 CLEAR_ERR. Others: tag only.
//  RX FSM:
//    - RX_IDLE -> RX_WAIT when running & sync_ready & !s_valid. On entry: s_data<=rx_data, s_valid<=1, rx_ack<=1, rx_cnt++ (8b, wraps).
//    - RX_WAIT -> RX_IDLE when !sync_ready. On exit: rx_ack<=0.
//    - s_valid clears on s_valid & s_ready. If s_ready stays low, the next HPS word is not acked.
//  TX FIFO:
//    - Push on r_valid & r_ready. r_ready = !full.
//    - Simultaneous push and pop: count unchanged. Pointers wrap modulo TX_DEPTH.
//  TX FSM (independent of running):
//    - TX_IDLE -> TX_WAIT when sync_req & !empty. On entry: tx_data<=head, tx_ack<=1.
//    - TX_WAIT -> TX_IDLE when !sync_req. On exit: tx_ack<=0, pop.
//    - Request while FIFO empty: stays in TX_IDLE until data arrives.
//  FLUSH: FIFO emptied and s_valid<=0 in the same clk. If TX is in TX_WAIT at the time, the pop at TX_WAIT exit is suppressed.
//    - Handshakes in progress complete normally. tx_data holds its last value.
//  STOP mid-RX-handshake: the current handshake completes. No new capture starts.
//  status: [31:24] last_tag, [23:16] fifo count, [15:8] rx_cnt, [7:4] 0, [3] wdog_err, [2] !empty, [1] s_valid, [0] running.
//    - status is registered.
// CONFIGURATION
//  HPS_BRIDGE_WDOG_EN defined:
//    - Per-FSM counter runs while in RX_WAIT or TX_WAIT.
//    - When it reaches WDOG_CYCLES: the ack drops, the FSM returns to IDLE, and wdog_err (sticky) is set.
//    - A TX timeout does not pop. wdog_err is cleared only by CLEAR_ERR or reset.
//  Undefined: no counters, status[3]=0, FSMs wait indefinitely.
// TESTING
//  T1 reset, hps_cmd=32'h01000001 -> status[0]=1, status[31:24]=8'h01 within 3 clks. Same cmd again -> no re-execute.
//  T2 running, rx_data=128'hDEADBEEF.., ready=1, s_ready=0 -> rx_ack=1, s_valid=1, s_data matches. Ready=0 -> rx_ack=0.
//     Second word stays unacked until s_ready=1.
//  T3 push 3 results A,B,C, then 3 HPS req/drop cycles -> tx_data A,B,C in order. status[23:16] goes 3->0.
//  T4 TX_DEPTH=8: 8 pushes -> r_ready=0. Simultaneous push+pop at count 8 -> r_ready stays 0.
//     Push+pop at count 5 -> count stays 5. Pointers wrap.
//  T5 5 entries, FLUSH (cmd 32'h02000003) -> count 0, r_ready=1, s_valid=0. Pending tx_ack completes with no pop.
//  T6 WDOG_EN, WDOG_CYCLES=16: hold tx_read_request=1 -> tx_ack drops after 16 clks, status[3]=1, count unchanged.
//     CLEAR_ERR -> status[3]=0. Assert reset_reset mid-handshake -> all outputs 0 immediately.

Source files
------------

// File: rtl/hps_bridge_ctrl_if.sv
// Bus bundle between the HPS PIO bridge, the HPS side and the recognition datapath.
// The slave modport is the bridge controller; the master modport is everything around it.
interface hps_bridge_ctrl_if;
  logic [31:0]  hps_cmd;
  logic [127:0] rx_data;
  logic         rx_data_ready;
  logic         rx_ack;
  logic [127:0] tx_data;
  logic         tx_read_request;
  logic         tx_ack;
  logic [127:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] r_data;
  logic         r_valid;
  logic         r_ready;
  logic [31:0]  status;

  modport slave (
    input  hps_cmd, rx_data, rx_data_ready, tx_read_request, s_ready, r_data, r_valid,
    output rx_ack, tx_data, tx_ack, s_data, s_valid, r_ready, status
  );

  modport master (
    output hps_cmd, rx_data, rx_data_ready, tx_read_request, s_ready, r_data, r_valid,
    input  rx_ack, tx_data, tx_ack, s_data, s_valid, r_ready, status
  );
endinterface

// File: rtl/hps_bridge_ctrl.sv
// HPS<->FPGA 128-bit PIO bridge sequencer: command decode, 4-phase RX/TX handshakes, result FIFO.
// Optional handshake watchdog enabled by defining HPS_BRIDGE_WDOG_EN.
module hps_bridge_ctrl #(
  parameter int TX_DEPTH    = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  hps_bridge_ctrl_if.slave  bus
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  if (TX_DEPTH < 2 || TX_DEPTH > 128 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 || WDOG_CYCLES < 2)
  begin : g_bad_param
    $error("hps_bridge_ctrl: illegal TX_DEPTH or WDOG_CYCLES");
  end

  typedef enum logic {RX_IDLE, RX_WAIT} rx_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

  logic [1:0]    meta_reg, sync_reg;
  logic          rx_sync, tx_sync;
  logic [31:0]   cmd_q1_reg, cmd_q2_reg;
  logic [7:0]    last_tag_reg, last_tag_next;
  logic          running_reg, running_next;
  logic          wdog_err_reg, wdog_err_next;
  rx_state_t     rx_state_reg, rx_state_next;
  tx_state_t     tx_state_reg, tx_state_next;
  logic [127:0]  s_data_reg, s_data_next;
  logic          s_valid_reg, s_valid_next;
  logic          rx_ack_reg, rx_ack_next;
  logic [7:0]    rx_cnt_reg, rx_cnt_next;
  logic [127:0]  tx_data_reg;
  logic          tx_ack_reg, tx_ack_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pop_skip_reg, pop_skip_next;
  logic          r_ready_reg, r_ready_next;
  logic [31:0]   status_reg, status_next;
  logic          cmd_exec, flush, push_en, pop_en, tx_load;
  logic          rx_timeout, tx_timeout, rx_block, tx_block;
  logic [127:0]  tx_mem [TX_DEPTH];

  assign rx_sync = sync_reg[0];
  assign tx_sync = sync_reg[1];

`ifdef HPS_BRIDGE_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] rx_wd_reg, tx_wd_reg;
  logic          rx_block_reg, tx_block_reg;

  assign rx_timeout = (rx_state_reg == RX_WAIT) && (rx_wd_reg == WW'(WDOG_CYCLES - 1));
  assign tx_timeout = (tx_state_reg == TX_WAIT) && (tx_wd_reg == WW'(WDOG_CYCLES - 1));
  assign rx_block   = rx_block_reg;
  assign tx_block   = tx_block_reg;

  // After a timeout the HPS must drop its level before a new handshake may start.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rx_wd_reg    <= '0;
      tx_wd_reg    <= '0;
      rx_block_reg <= 1'b0;
      tx_block_reg <= 1'b0;
    end else begin
      rx_wd_reg <= (rx_state_reg == RX_WAIT && !rx_timeout) ? rx_wd_reg + 1'b1 : '0;
      tx_wd_reg <= (tx_state_reg == TX_WAIT && !tx_timeout) ? tx_wd_reg + 1'b1 : '0;
      if (rx_timeout)   rx_block_reg <= 1'b1;
      else if (!rx_sync) rx_block_reg <= 1'b0;
      if (tx_timeout)   tx_block_reg <= 1'b1;
      else if (!tx_sync) tx_block_reg <= 1'b0;
    end
  end
`else
  assign rx_timeout = 1'b0;
  assign tx_timeout = 1'b0;
  assign rx_block   = 1'b0;
  assign tx_block   = 1'b0;
`endif

  assign cmd_exec = (cmd_q1_reg == cmd_q2_reg) && (cmd_q2_reg[31:24] != last_tag_reg);
  assign flush    = cmd_exec && (cmd_q2_reg[7:0] == 8'h03);

  always_comb begin
    last_tag_next = last_tag_reg;
    running_next  = running_reg;
    wdog_err_next = wdog_err_reg;
    rx_state_next = rx_state_reg;
    tx_state_next = tx_state_reg;
    s_data_next   = s_data_reg;
    s_valid_next  = s_valid_reg;
    rx_ack_next   = rx_ack_reg;
    rx_cnt_next   = rx_cnt_reg;
    tx_ack_next   = tx_ack_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    pop_skip_next = pop_skip_reg;
    tx_load       = 1'b0;
    pop_en        = 1'b0;
    push_en       = 1'b0;

    if (cmd_exec) begin
      last_tag_next = cmd_q2_reg[31:24];
      case (cmd_q2_reg[7:0])
        8'h01:   running_next  = 1'b1;
        8'h02:   running_next  = 1'b0;
        8'h04:   wdog_err_next = 1'b0;
        default: ;
      endcase
    end
    if (rx_timeout || tx_timeout) wdog_err_next = 1'b1;

    if (s_valid_reg && bus.s_ready) s_valid_next = 1'b0;
    case (rx_state_reg)
      RX_IDLE: if (running_reg && rx_sync && !s_valid_reg && !rx_block) begin
        rx_state_next = RX_WAIT;
        s_data_next   = bus.rx_data;
        s_valid_next  = 1'b1;
        rx_ack_next   = 1'b1;
        rx_cnt_next   = rx_cnt_reg + 8'd1;
      end
      RX_WAIT: if (!rx_sync || rx_timeout) begin
        rx_state_next = RX_IDLE;
        rx_ack_next   = 1'b0;
      end
    endcase
    if (flush) s_valid_next = 1'b0;

    case (tx_state_reg)
      TX_IDLE: if (tx_sync && count_reg != '0 && !tx_block) begin
        tx_state_next = TX_WAIT;
        tx_ack_next   = 1'b1;
        tx_load       = 1'b1;
      end
      TX_WAIT: if (!tx_sync || tx_timeout) begin
        tx_state_next = TX_IDLE;
        tx_ack_next   = 1'b0;
        pop_en        = !tx_timeout && !pop_skip_reg && !flush;
        pop_skip_next = 1'b0;
      end
    endcase
    // A handshake that survives a flush must not pop the entry it was serving.
    if (flush && tx_state_next == TX_WAIT) pop_skip_next = 1'b1;

    if (flush) begin
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      push_en = bus.r_valid && r_ready_reg;
      if (push_en) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_next = rd_ptr_reg + 1'b1;
      count_next = count_reg + CW'(push_en) - CW'(pop_en);
    end

    r_ready_next = (count_next != CW'(TX_DEPTH));
    status_next  = {last_tag_next, 8'(count_next), rx_cnt_next, 4'b0000,
                    wdog_err_next, (count_next != '0), s_valid_next, running_next};
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      meta_reg     <= '0;
      sync_reg     <= '0;
      cmd_q1_reg   <= '0;
      cmd_q2_reg   <= '0;
      last_tag_reg <= '0;
      running_reg  <= 1'b0;
      wdog_err_reg <= 1'b0;
      rx_state_reg <= RX_IDLE;
      tx_state_reg <= TX_IDLE;
      s_data_reg   <= '0;
      s_valid_reg  <= 1'b0;
      rx_ack_reg   <= 1'b0;
      rx_cnt_reg   <= '0;
      tx_ack_reg   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_skip_reg <= 1'b0;
      r_ready_reg  <= 1'b0;
      status_reg   <= '0;
    end else begin
      meta_reg     <= {bus.tx_read_request, bus.rx_data_ready};
      sync_reg     <= meta_reg;
      cmd_q1_reg   <= bus.hps_cmd;
      cmd_q2_reg   <= cmd_q1_reg;
      last_tag_reg <= last_tag_next;
      running_reg  <= running_next;
      wdog_err_reg <= wdog_err_next;
      rx_state_reg <= rx_state_next;
      tx_state_reg <= tx_state_next;
      s_data_reg   <= s_data_next;
      s_valid_reg  <= s_valid_next;
      rx_ack_reg   <= rx_ack_next;
      rx_cnt_reg   <= rx_cnt_next;
      tx_ack_reg   <= tx_ack_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      pop_skip_reg <= pop_skip_next;
      r_ready_reg  <= r_ready_next;
      status_reg   <= status_next;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push_en) tx_mem[wr_ptr_reg] <= bus.r_data;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)  tx_data_reg <= '0;
    else if (tx_load) tx_data_reg <= tx_mem[rd_ptr_reg];
  end

  assign bus.rx_ack  = rx_ack_reg;
  assign bus.s_data  = s_data_reg;
  assign bus.s_valid = s_valid_reg;
  assign bus.tx_data = tx_data_reg;
  assign bus.tx_ack  = tx_ack_reg;
  assign bus.r_ready = r_ready_reg;
  assign bus.status  = status_reg;
endmodule

// File: tb/tb_hps_bridge_ctrl.sv
// Directed bench for hps_bridge_ctrl with scoreboard queues for datapath words and results.
// Watchdog section is compiled when HPS_BRIDGE_WDOG_EN is defined.
module tb_hps_bridge_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_count = 0;
  logic [127:0] rx_q [$];
  logic [127:0] tx_q [$];

  always #5 clk = ~clk;

  hps_bridge_ctrl_if bus ();

  hps_bridge_ctrl #(.TX_DEPTH(8), .WDOG_CYCLES(16)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_sig(input int which);
    return (which == 0) ? bus.rx_ack : bus.tx_ack;
  endfunction

  task automatic wait_level(input string tag, input int which, input logic level);
    for (int i = 0; i < 64; i++) begin
      if (ack_sig(which) === level) break;
      tick(1);
    end
    check(tag, 128'(ack_sig(which)), 128'(level));
  endtask

  task automatic send_cmd(input logic [7:0] tag, input logic [7:0] op);
    bus.hps_cmd = {tag, 16'h0000, op};
    tick(3);
    $display("cmd tag=%h op=%h status=%h", tag, op, bus.status);
  endtask

  task automatic push_result(input logic [127:0] d);
    bus.r_data  = d;
    bus.r_valid = 1'b1;
    if (bus.r_ready) begin
      tx_q.push_back(d);
      exp_count++;
    end
    tick(1);
    bus.r_valid = 1'b0;
    $display("push %h r_ready=%b count=%0d", d, bus.r_ready, exp_count);
  endtask

  task automatic rx_word(input string tag, input logic [127:0] d);
    logic [127:0] exp;
    bus.rx_data = d;
    bus.rx_data_ready = 1'b1;
    rx_q.push_back(d);
    wait_level({tag, "_ack_rise"}, 0, 1'b1);
    exp = rx_q.pop_front();
    check({tag, "_s_data"}, bus.s_data, exp);
    $display("rx %s s_data=%h", tag, bus.s_data);
  endtask

  task automatic tx_pop(input string tag);
    logic [127:0] exp;
    bus.tx_read_request = 1'b1;
    wait_level({tag, "_ack_rise"}, 1, 1'b1);
    exp = (tx_q.size() != 0) ? tx_q.pop_front() : 'x;
    check({tag, "_tx_data"}, bus.tx_data, exp);
    bus.tx_read_request = 1'b0;
    wait_level({tag, "_ack_fall"}, 1, 1'b0);
    exp_count--;
    check({tag, "_count"}, 128'(bus.status[23:16]), 128'(exp_count));
    $display("tx %s tx_data=%h count=%0d", tag, bus.tx_data, bus.status[23:16]);
  endtask

  initial begin
    bus.hps_cmd = '0;
    bus.rx_data = '0;
    bus.rx_data_ready = 1'b0;
    bus.tx_read_request = 1'b0;
    bus.s_ready = 1'b0;
    bus.r_data = '0;
    bus.r_valid = 1'b0;
    tick(3);
    check("rst_status", 128'(bus.status), 128'd0);
    check("rst_rx_ack", 128'(bus.rx_ack), 128'd0);
    check("rst_tx_ack", 128'(bus.tx_ack), 128'd0);
    check("rst_s_valid", 128'(bus.s_valid), 128'd0);
    check("rst_r_ready", 128'(bus.r_ready), 128'd0);
    check("rst_tx_data", bus.tx_data, 128'd0);
    rst = 1'b0;
    tick(1);
    check("r_ready_after_rst", 128'(bus.r_ready), 128'd1);

    // T1: START with exact 3-clock latency, then same tag must not re-execute
    bus.hps_cmd = 32'h01000001;
    tick(2);
    check("start_early", 128'(bus.status[0]), 128'd0);
    tick(1);
    check("start_running", 128'(bus.status[0]), 128'd1);
    check("start_tag", 128'(bus.status[31:24]), 128'h01);
    send_cmd(8'h01, 8'h02);
    check("same_tag_ignored", 128'(bus.status[0]), 128'd1);

    // T2: capture with s_ready low, back-pressure on second word
    rx_word("w1", {4{32'hDEADBEEF}});
    check("w1_s_valid", 128'(bus.s_valid), 128'd1);
    bus.rx_data_ready = 1'b0;
    wait_level("w1_ack_fall", 0, 1'b0);
    bus.rx_data = {4{32'h12345678}};
    bus.rx_data_ready = 1'b1;
    tick(8);
    check("w2_unacked", 128'(bus.rx_ack), 128'd0);
    check("w2_s_data_held", bus.s_data, {4{32'hDEADBEEF}});
    bus.s_ready = 1'b1;
    rx_word("w2", {4{32'h12345678}});
    check("rx_cnt_2", 128'(bus.status[15:8]), 128'd2);
    bus.rx_data_ready = 1'b0;
    wait_level("w2_ack_fall", 0, 1'b0);

    // STOP mid-handshake: handshake completes, no new capture
    rx_word("w3", {4{32'hCAFEF00D}});
    send_cmd(8'h10, 8'h02);
    check("stop_running", 128'(bus.status[0]), 128'd0);
    check("stop_ack_held", 128'(bus.rx_ack), 128'd1);
    bus.rx_data_ready = 1'b0;
    wait_level("w3_ack_fall", 0, 1'b0);
    bus.rx_data = {4{32'h0BADF00D}};
    bus.rx_data_ready = 1'b1;
    tick(8);
    check("stopped_no_ack", 128'(bus.rx_ack), 128'd0);
    check("rx_cnt_3", 128'(bus.status[15:8]), 128'd3);
    bus.rx_data_ready = 1'b0;
    tick(3);

    // Restart and leave one word pending in s_valid for the flush test
    send_cmd(8'h11, 8'h01);
    bus.s_ready = 1'b0;
    rx_word("w5", {4{32'h55AA55AA}});
    bus.rx_data_ready = 1'b0;
    wait_level("w5_ack_fall", 0, 1'b0);

    // T3: three results, drained in order
    push_result({4{32'hAAAA0001}});
    push_result({4{32'hBBBB0002}});
    push_result({4{32'hCCCC0003}});
    check("t3_count3", 128'(bus.status[23:16]), 128'd3);
    check("t3_not_empty", 128'(bus.status[2]), 128'd1);
    tx_pop("t3a");
    tx_pop("t3b");
    tx_pop("t3c");

    // T4: fill, full back-pressure, pop while r_valid held at full
    for (int i = 0; i < 8; i++) push_result(128'(32'h4000_0000 + i));
    check("t4_full_r_ready", 128'(bus.r_ready), 128'd0);
    push_result(128'hDEAD);
    check("t4_full_count", 128'(bus.status[23:16]), 128'd8);
    bus.tx_read_request = 1'b1;
    wait_level("t4_full_ack_rise", 1, 1'b1);
    check("t4_full_tx_data", bus.tx_data, tx_q.pop_front());
    bus.r_data = 128'hBEEF;
    bus.r_valid = 1'b1;
    bus.tx_read_request = 1'b0;
    for (int i = 0; i < 64 && bus.tx_ack; i++) begin
      check("t4_r_ready_low_at_full", 128'(bus.r_ready), 128'd0);
      tick(1);
    end
    bus.r_valid = 1'b0;
    exp_count--;
    check("t4_after_pop_count", 128'(bus.status[23:16]), 128'd7);
    check("t4_after_pop_r_ready", 128'(bus.r_ready), 128'd1);
    tx_pop("t4_to6");
    tx_pop("t4_to5");
    // Push in the same clock as the pop at count 5
    bus.tx_read_request = 1'b1;
    wait_level("t4_sim_ack_rise", 1, 1'b1);
    check("t4_sim_tx_data", bus.tx_data, tx_q.pop_front());
    bus.tx_read_request = 1'b0;
    tick(2);
    bus.r_data = {4{32'h5A5A5A5A}};
    bus.r_valid = 1'b1;
    if (bus.r_ready) tx_q.push_back({4{32'h5A5A5A5A}});
    tick(1);
    bus.r_valid = 1'b0;
    check("t4_sim_ack_fell", 128'(bus.tx_ack), 128'd0);
    check("t4_sim_count5", 128'(bus.status[23:16]), 128'd5);
    $display("push+pop at 5 count=%0d", bus.status[23:16]);
    for (int i = 0; i < 5; i++) tx_pop("t4_drain");

    // T5: flush with a TX handshake in progress
    for (int i = 0; i < 5; i++) push_result(128'(32'h5000_0000 + i));
    bus.tx_read_request = 1'b1;
    wait_level("t5_ack_rise", 1, 1'b1);
    check("t5_tx_data", bus.tx_data, tx_q.pop_front());
    send_cmd(8'h02, 8'h03);
    tx_q.delete();
    exp_count = 0;
    check("t5_count0", 128'(bus.status[23:16]), 128'd0);
    check("t5_r_ready", 128'(bus.r_ready), 128'd1);
    check("t5_s_valid", 128'(bus.s_valid), 128'd0);
    check("t5_status_s_valid", 128'(bus.status[1]), 128'd0);
    check("t5_ack_pending", 128'(bus.tx_ack), 128'd1);
    check("t5_tx_data_held", bus.tx_data, 128'(32'h5000_0000));
    bus.tx_read_request = 1'b0;
    wait_level("t5_ack_fall", 1, 1'b0);
    tick(1);
    check("t5_no_pop", 128'(bus.status[23:16]), 128'd0);
    push_result({4{32'hF00DF00D}});
    tx_pop("t5_after");

`ifdef HPS_BRIDGE_WDOG_EN
    // T6: TX watchdog timeout and CLEAR_ERR
    begin
      int cycles;
      push_result({4{32'h60606060}});
      bus.tx_read_request = 1'b1;
      wait_level("t6_ack_rise", 1, 1'b1);
      cycles = 0;
      while (bus.tx_ack && cycles < 40) begin
        tick(1);
        cycles++;
      end
      check("t6_timeout_cycles", 128'(cycles), 128'd16);
      check("t6_wdog_err", 128'(bus.status[3]), 128'd1);
      check("t6_count_kept", 128'(bus.status[23:16]), 128'd1);
      $display("watchdog fired after %0d clks", cycles);
      bus.tx_read_request = 1'b0;
      tick(4);
      send_cmd(8'h20, 8'h04);
      check("t6_err_cleared", 128'(bus.status[3]), 128'd0);
      tx_pop("t6_after");
    end
`else
    push_result({4{32'h60606060}});
    bus.tx_read_request = 1'b1;
    wait_level("t6_ack_rise", 1, 1'b1);
    tick(30);
    check("t6_no_timeout", 128'(bus.tx_ack), 128'd1);
    check("t6_no_err", 128'(bus.status[3]), 128'd0);
    bus.tx_read_request = 1'b0;
    wait_level("t6_ack_fall", 1, 1'b0);
    exp_count--;
    void'(tx_q.pop_front());
    check("t6_count0", 128'(bus.status[23:16]), 128'd0);
`endif

    // Asynchronous reset in the middle of a TX handshake
    push_result({4{32'h70707070}});
    bus.tx_read_request = 1'b1;
    wait_level("rst_mid_ack_rise", 1, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_tx_ack", 128'(bus.tx_ack), 128'd0);
    check("rst_mid_tx_data", bus.tx_data, 128'd0);
    check("rst_mid_status", 128'(bus.status), 128'd0);
    check("rst_mid_r_ready", 128'(bus.r_ready), 128'd0);
    check("rst_mid_s_data", bus.s_data, 128'd0);
    $display("async reset mid-handshake status=%h", bus.status);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
